// File: rtl/als_poll_scheduler.sv
// Ambient-light-sensor poll scheduler: periodic/forced reads with a response timeout,
// plus a clamped box filter that publishes CCT only on significant change.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | polling disabled, waiting for enable or a forced request
// ISSUE      | waiting for the ALS interface to go idle, then request a read
// WAIT_RESP  | waiting for a CCT sample or the response timeout
// PROCESS    | update the filter and decide whether to publish
// WAIT_TICK  | waiting for the next poll slot (or a forced request)
module als_poll_scheduler #(
    parameter int unsigned POLL_CYCLES    = 5_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned CCT_MIN        = 1000,
    parameter int unsigned CCT_MAX        = 40000,
    parameter int unsigned CHANGE_THRESH  = 100,
    parameter int unsigned DEFAULT_CCT    = 6500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        force_req,
    output logic        als_read_req,
    input  logic        als_busy,
    input  logic [15:0] als_cct,
    input  logic        als_cct_valid,
    output logic [15:0] cct_out,
    output logic        cct_update,
    output logic        err_timeout,
    output logic [7:0]  err_count,
    output logic        sched_busy
);

    localparam int unsigned DEPTH  = 1 << AVG_LOG2;
    localparam int unsigned PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SUM_W  = 16 + AVG_LOG2;
    localparam int unsigned POLL_W = $clog2(POLL_CYCLES);
    localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RESP,
        S_PROCESS,
        S_WAIT_TICK
    } state_t;

    state_t              state_q, state_d;
    logic [POLL_W-1:0]   poll_cnt_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic                force_pending_q;
    logic [15:0]         sample_q;
    logic [15:0]         ring_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [SUM_W-1:0]    sum_q;
    logic                primed_q;
    logic [15:0]         cct_out_q;
    logic                cct_update_q;
    logic [7:0]          err_count_q;

    logic                read_req_c;
    logic                timeout_c;
    logic                force_any;
    logic                poll_done;
    logic                tmo_done;
    logic                issue_entry;
    logic [15:0]         clamped;
    logic [15:0]         oldest;
    logic [SUM_W-1:0]    sum_next;
    logic [15:0]         avg;
    logic signed [16:0]  diff;
    logic [16:0]         abs_diff;
    logic                publish;
    logic [PTR_W-1:0]    ptr_next;

    assign force_any   = force_req | force_pending_q;
    assign poll_done   = (poll_cnt_q == '0);
    assign tmo_done    = (tmo_cnt_q == '0);
    assign issue_entry = (state_d == S_ISSUE) && (state_q != S_ISSUE);

    always_comb begin
        state_d    = state_q;
        read_req_c = 1'b0;
        timeout_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable || force_any)
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!als_busy) begin
                    read_req_c = 1'b1;
                    state_d    = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (als_cct_valid) begin
                    state_d = S_PROCESS;
                end else if (tmo_done) begin
                    timeout_c = 1'b1;
                    state_d   = S_WAIT_TICK;
                end
            end
            S_PROCESS: begin
                state_d = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (force_any)
                    state_d = S_ISSUE;
                else if (poll_done)
                    state_d = enable ? S_ISSUE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Clamp at capture so the filter only ever sees in-range Kelvin values.
    always_comb begin
        clamped = als_cct;
        if (als_cct < 16'(CCT_MIN))
            clamped = 16'(CCT_MIN);
        else if (als_cct > 16'(CCT_MAX))
            clamped = 16'(CCT_MAX);
    end

    // Running sum never goes negative overall, so modular add/subtract is exact.
    assign oldest   = ring_q[wr_ptr_q];
    assign sum_next = sum_q + SUM_W'(sample_q) - SUM_W'(oldest);
    assign avg      = sum_next[AVG_LOG2 +: 16];
    assign diff     = signed'({1'b0, avg}) - signed'({1'b0, cct_out_q});
    assign abs_diff = (diff < 0) ? 17'(-diff) : 17'(diff);
    assign publish  = (abs_diff >= 17'(CHANGE_THRESH));
    assign ptr_next = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            poll_cnt_q      <= '0;
            tmo_cnt_q       <= '0;
            force_pending_q <= 1'b0;
            sample_q        <= '0;
            for (int i = 0; i < int'(DEPTH); i++)
                ring_q[i] <= '0;
            wr_ptr_q        <= '0;
            sum_q           <= '0;
            primed_q        <= 1'b0;
            cct_out_q       <= 16'(DEFAULT_CCT);
            cct_update_q    <= 1'b0;
            err_count_q     <= '0;
        end else begin
            state_q      <= state_d;
            cct_update_q <= 1'b0;

            if (issue_entry)
                poll_cnt_q <= POLL_W'(POLL_CYCLES - 1);
            else if (!poll_done)
                poll_cnt_q <= poll_cnt_q - POLL_W'(1);

            if (state_q == S_ISSUE)
                tmo_cnt_q <= TMO_W'(TIMEOUT_CYCLES - 1);
            else if (state_q == S_WAIT_RESP && !tmo_done)
                tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);

            if (issue_entry)
                force_pending_q <= 1'b0;
            else if (force_req && state_q != S_IDLE && state_q != S_WAIT_TICK)
                force_pending_q <= 1'b1;

            if (state_q == S_WAIT_RESP && als_cct_valid)
                sample_q <= clamped;

            if (timeout_c && err_count_q != 8'hFF)
                err_count_q <= err_count_q + 8'd1;

            if (state_q == S_PROCESS) begin
                if (!primed_q) begin
                    for (int i = 0; i < int'(DEPTH); i++)
                        ring_q[i] <= sample_q;
                    sum_q        <= SUM_W'(sample_q) << AVG_LOG2;
                    wr_ptr_q     <= '0;
                    primed_q     <= 1'b1;
                    cct_out_q    <= sample_q;
                    cct_update_q <= 1'b1;
                end else begin
                    ring_q[wr_ptr_q] <= sample_q;
                    wr_ptr_q         <= ptr_next;
                    sum_q            <= sum_next;
                    if (publish) begin
                        cct_out_q    <= avg;
                        cct_update_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign als_read_req = read_req_c & ~rst;
    assign err_timeout  = timeout_c & ~rst;
    assign cct_out      = cct_out_q;
    assign cct_update   = cct_update_q;
    assign err_count    = err_count_q;
    assign sched_busy   = (state_q == S_ISSUE) || (state_q == S_WAIT_RESP) || (state_q == S_PROCESS);

endmodule
